// File: rtl/divergence_ctrl.sv
// SIMT branch-divergence controller: turns IF/ELSE/ENDIF ops into predicate-stack strobes
// and redirects the warp PC past a branch body when no lane is active in it.
module divergence_ctrl #(
  parameter int N_CORES     = 4,
  parameter int STACK_DEPTH = 3,
  parameter int PC_W        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [1:0]             op_code,
  input  logic [N_CORES-1:0]     op_pred,
  input  logic [PC_W-1:0]        op_target,
  input  logic [N_CORES-1:0]     stk_tos,
  input  logic                   stk_all_false,
  output logic                   stk_push,
  output logic                   stk_pop,
  output logic                   stk_comp,
  output logic [N_CORES-1:0]     stk_d_in,
  output logic                   redirect_valid,
  output logic [PC_W-1:0]        redirect_pc,
  output logic [STACK_DEPTH-1:0] depth,
  output logic                   ovf_err,
  output logic                   unf_err
);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_IF    = 2'b01;
  localparam logic [1:0] OP_ELSE  = 2'b10;
  localparam logic [1:0] OP_ENDIF = 2'b11;

  localparam logic [STACK_DEPTH-1:0] MAX_DEPTH  = {STACK_DEPTH{1'b1}};
  localparam logic [STACK_DEPTH-1:0] ZERO_DEPTH = '0;
  localparam logic [STACK_DEPTH-1:0] ONE_DEPTH  = {{(STACK_DEPTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [STACK_DEPTH-1:0] depth_reg, depth_next;
  logic [1:0]             op_code_reg, op_code_next;
  logic [PC_W-1:0]        op_target_reg, op_target_next;
  logic                   op_err_reg, op_err_next;
  logic                   push_reg, push_next;
  logic                   pop_reg, pop_next;
  logic                   comp_reg, comp_next;
  logic [N_CORES-1:0]     d_in_reg, d_in_next;
  logic                   ovf_reg, ovf_next;
  logic                   unf_reg, unf_next;
  logic [PC_W-1:0]        redirect_pc_reg, redirect_pc_next;

  logic                   accept;
  logic                   redirect_fire;
  logic [N_CORES-1:0]     masked_pred;

  // New mask only keeps lanes that are both predicated and already active.
  generate
    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_mask
      assign masked_pred[gi] = op_pred[gi] & stk_tos[gi];
    end
  endgenerate

  assign accept = op_valid && (state_reg == S_IDLE);

  // all_false is read combinationally in CHECK so it reflects the stack after its update.
  assign redirect_fire = (state_reg == S_CHECK) && !op_err_reg && stk_all_false &&
                         ((op_code_reg == OP_IF) || (op_code_reg == OP_ELSE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      depth_reg       <= '0;
      op_code_reg     <= OP_NOP;
      op_target_reg   <= '0;
      op_err_reg      <= 1'b0;
      push_reg        <= 1'b0;
      pop_reg         <= 1'b0;
      comp_reg        <= 1'b0;
      d_in_reg        <= '0;
      ovf_reg         <= 1'b0;
      unf_reg         <= 1'b0;
      redirect_pc_reg <= '0;
    end else begin
      state_reg       <= state_next;
      depth_reg       <= depth_next;
      op_code_reg     <= op_code_next;
      op_target_reg   <= op_target_next;
      op_err_reg      <= op_err_next;
      push_reg        <= push_next;
      pop_reg         <= pop_next;
      comp_reg        <= comp_next;
      d_in_reg        <= d_in_next;
      ovf_reg         <= ovf_next;
      unf_reg         <= unf_next;
      redirect_pc_reg <= redirect_pc_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    depth_next       = depth_reg;
    op_code_next     = op_code_reg;
    op_target_next   = op_target_reg;
    op_err_next      = op_err_reg;
    push_next        = 1'b0;
    pop_next         = 1'b0;
    comp_next        = 1'b0;
    d_in_next        = d_in_reg;
    ovf_next         = ovf_reg;
    unf_next         = unf_reg;
    redirect_pc_next = redirect_pc_reg;

    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          op_code_next   = op_code;
          op_target_next = op_target;
          op_err_next    = 1'b0;
          case (op_code)
            OP_IF: begin
              state_next = S_ISSUE;
              if (depth_reg == MAX_DEPTH) begin
                ovf_next    = 1'b1;
                op_err_next = 1'b1;
              end else begin
                push_next  = 1'b1;
                d_in_next  = masked_pred;
                depth_next = depth_reg + ONE_DEPTH;
              end
            end
            OP_ELSE: begin
              state_next = S_ISSUE;
              if (depth_reg == ZERO_DEPTH) begin
                unf_next    = 1'b1;
                op_err_next = 1'b1;
              end else begin
                comp_next = 1'b1;
              end
            end
            OP_ENDIF: begin
              state_next = S_ISSUE;
              if (depth_reg == ZERO_DEPTH) begin
                unf_next    = 1'b1;
                op_err_next = 1'b1;
              end else begin
                pop_next   = 1'b1;
                depth_next = depth_reg - ONE_DEPTH;
              end
            end
            default: state_next = S_IDLE;
          endcase
        end
      end
      S_ISSUE: state_next = S_CHECK;
      S_CHECK: begin
        state_next = S_IDLE;
        if (redirect_fire) redirect_pc_next = op_target_reg;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign op_ready       = (state_reg == S_IDLE);
  assign stk_push       = push_reg;
  assign stk_pop        = pop_reg;
  assign stk_comp       = comp_reg;
  assign stk_d_in       = d_in_reg;
  assign redirect_valid = redirect_fire;
  assign redirect_pc    = redirect_fire ? op_target_reg : redirect_pc_reg;
  assign depth          = depth_reg;
  assign ovf_err        = ovf_reg;
  assign unf_err        = unf_reg;

endmodule

// File: tb/tb_divergence_ctrl.sv
// Directed bench for divergence_ctrl; the stack is emulated by driving tos/all_false by hand.
module tb_divergence_ctrl;

  logic       clk;
  logic       reset;
  logic       op_valid;
  logic       op_ready;
  logic [1:0] op_code;
  logic [3:0] op_pred;
  logic [7:0] op_target;
  logic [3:0] stk_tos;
  logic       stk_all_false;
  logic       stk_push, stk_pop, stk_comp;
  logic [3:0] stk_d_in;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic [2:0] depth;
  logic       ovf_err, unf_err;

  int checks;
  int failures;

  divergence_ctrl #(.N_CORES(4), .STACK_DEPTH(3), .PC_W(8)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_pred(op_pred), .op_target(op_target),
    .stk_tos(stk_tos), .stk_all_false(stk_all_false),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_comp(stk_comp), .stk_d_in(stk_d_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .depth(depth), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one op at a negedge; returns #1 after the accepting edge (ISSUE cycle).
  task automatic send_op(input logic [1:0] code, input logic [3:0] pred, input logic [7:0] tgt);
    @(negedge clk);
    op_valid  = 1'b1;
    op_code   = code;
    op_pred   = pred;
    op_target = tgt;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; op_valid = 1'b0; op_code = 2'b00; op_pred = '0; op_target = '0;
    stk_tos = 4'b1111; stk_all_false = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (op_ready !== 1'b1 || depth !== 3'd0 || stk_push !== 1'b0 || stk_pop !== 1'b0 ||
        stk_comp !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 8'h00 ||
        ovf_err !== 1'b0 || unf_err !== 1'b0 || stk_d_in !== 4'h0) begin
      failures++;
      $display("FAIL reset_state: ready=%b depth=%0d push=%b pop=%b comp=%b rv=%b pc=%h ovf=%b unf=%b din=%b required ready=1 rest 0",
               op_ready, depth, stk_push, stk_pop, stk_comp, redirect_valid, redirect_pc, ovf_err, unf_err, stk_d_in);
    end
    @(negedge clk);
    reset = 1'b0;
    $display("txn reset: ready=%b depth=%0d", op_ready, depth);
  endtask

  task automatic test_nop();
    send_op(2'b00, 4'b1111, 8'h55);
    checks++;
    if (op_ready !== 1'b1 || stk_push !== 1'b0 || stk_pop !== 1'b0 || stk_comp !== 1'b0 || depth !== 3'd0) begin
      failures++;
      $display("FAIL nop: ready=%b push=%b pop=%b comp=%b depth=%0d required ready=1 strobes 0 depth 0",
               op_ready, stk_push, stk_pop, stk_comp, depth);
    end
    $display("txn NOP: ready=%b depth=%0d", op_ready, depth);
  endtask

  task automatic test_if_push();
    stk_tos = 4'b1111; stk_all_false = 1'b0;
    send_op(2'b01, 4'b1011, 8'h10);
    checks++;
    if (stk_push !== 1'b1 || stk_pop !== 1'b0 || stk_comp !== 1'b0 || stk_d_in !== 4'b1011 ||
        depth !== 3'd1 || op_ready !== 1'b0) begin
      failures++;
      $display("FAIL if_push_issue: push=%b pop=%b comp=%b din=%b depth=%0d ready=%b required 1 0 0 1011 1 0",
               stk_push, stk_pop, stk_comp, stk_d_in, depth, op_ready);
    end
    step();
    checks++;
    if (stk_push !== 1'b0 || redirect_valid !== 1'b0 || op_ready !== 1'b0) begin
      failures++;
      $display("FAIL if_push_check: push=%b rv=%b ready=%b required 0 0 0", stk_push, redirect_valid, op_ready);
    end
    step();
    checks++;
    if (op_ready !== 1'b1) begin
      failures++;
      $display("FAIL if_push_ready: ready=%b required 1", op_ready);
    end
    $display("txn IF pred=1011: din=%b depth=%0d", stk_d_in, depth);
    // ENDIF never redirects, even with all_false high
    send_op(2'b11, 4'b0000, 8'hEE);
    checks++;
    if (stk_pop !== 1'b1 || stk_push !== 1'b0 || stk_comp !== 1'b0 || depth !== 3'd0) begin
      failures++;
      $display("FAIL endif_pop: pop=%b push=%b comp=%b depth=%0d required 1 0 0 0", stk_pop, stk_push, stk_comp, depth);
    end
    stk_all_false = 1'b1;
    step();
    checks++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 8'h00) begin
      failures++;
      $display("FAIL endif_no_redirect: rv=%b pc=%h required 0 00", redirect_valid, redirect_pc);
    end
    step();
    stk_all_false = 1'b0;
    $display("txn ENDIF: depth=%0d rv=%b", depth, redirect_valid);
  endtask

  task automatic test_if_redirect();
    stk_tos = 4'b1111; stk_all_false = 1'b0;
    send_op(2'b01, 4'b0000, 8'h20);
    checks++;
    if (stk_push !== 1'b1 || stk_d_in !== 4'b0000 || depth !== 3'd1 || redirect_valid !== 1'b0) begin
      failures++;
      $display("FAIL if_zero_issue: push=%b din=%b depth=%0d rv=%b required 1 0000 1 0", stk_push, stk_d_in, depth, redirect_valid);
    end
    stk_all_false = 1'b1;
    step();
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 8'h20) begin
      failures++;
      $display("FAIL if_redirect: rv=%b pc=%h required 1 20", redirect_valid, redirect_pc);
    end
    step();
    checks++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 8'h20) begin
      failures++;
      $display("FAIL redirect_hold: rv=%b pc=%h required 0 20", redirect_valid, redirect_pc);
    end
    $display("txn IF pred=0000: redirect_pc=%h", redirect_pc);
    send_op(2'b11, 4'b0000, 8'h77);
    step();
    step();
    checks++;
    if (depth !== 3'd0 || redirect_pc !== 8'h20) begin
      failures++;
      $display("FAIL redirect_cleanup: depth=%0d pc=%h required 0 20", depth, redirect_pc);
    end
    stk_all_false = 1'b0;
  endtask

  task automatic test_if_else_endif();
    stk_tos = 4'b1111; stk_all_false = 1'b0;
    send_op(2'b01, 4'b1111, 8'h30);
    checks++;
    if (stk_push !== 1'b1 || stk_d_in !== 4'b1111 || depth !== 3'd1) begin
      failures++;
      $display("FAIL ife_if: push=%b din=%b depth=%0d required 1 1111 1", stk_push, stk_d_in, depth);
    end
    step();
    checks++;
    if (redirect_valid !== 1'b0) begin
      failures++;
      $display("FAIL ife_if_noredirect: rv=%b required 0", redirect_valid);
    end
    step();
    send_op(2'b10, 4'b0000, 8'h40);
    checks++;
    if (stk_comp !== 1'b1 || stk_push !== 1'b0 || stk_pop !== 1'b0 || depth !== 3'd1) begin
      failures++;
      $display("FAIL ife_else: comp=%b push=%b pop=%b depth=%0d required 1 0 0 1", stk_comp, stk_push, stk_pop, depth);
    end
    stk_all_false = 1'b1;
    step();
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 8'h40 || stk_comp !== 1'b0) begin
      failures++;
      $display("FAIL ife_else_redirect: rv=%b pc=%h comp=%b required 1 40 0", redirect_valid, redirect_pc, stk_comp);
    end
    step();
    stk_all_false = 1'b0;
    send_op(2'b11, 4'b0000, 8'h00);
    checks++;
    if (stk_pop !== 1'b1 || depth !== 3'd0) begin
      failures++;
      $display("FAIL ife_endif: pop=%b depth=%0d required 1 0", stk_pop, depth);
    end
    step();
    step();
    $display("txn IF/ELSE/ENDIF: redirect_pc=%h depth=%0d", redirect_pc, depth);
  endtask

  task automatic test_overflow_underflow();
    int pushes;
    int pops;
    pushes = 0;
    pops = 0;
    stk_tos = 4'b1111; stk_all_false = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send_op(2'b01, 4'b1111, 8'h50);
      if (stk_push === 1'b1) pushes++;
      step();
      step();
    end
    checks++;
    if (pushes != 7 || depth !== 3'd7 || ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL nest7: pushes=%0d depth=%0d ovf=%b required 7 7 0", pushes, depth, ovf_err);
    end
    send_op(2'b01, 4'b1111, 8'h60);
    checks++;
    if (stk_push !== 1'b0 || ovf_err !== 1'b1 || depth !== 3'd7) begin
      failures++;
      $display("FAIL overflow: push=%b ovf=%b depth=%0d required 0 1 7", stk_push, ovf_err, depth);
    end
    stk_all_false = 1'b1;
    step();
    checks++;
    if (redirect_valid !== 1'b0) begin
      failures++;
      $display("FAIL overflow_noredirect: rv=%b required 0", redirect_valid);
    end
    step();
    stk_all_false = 1'b0;
    $display("txn IF x8: depth=%0d ovf=%b", depth, ovf_err);
    for (int i = 0; i < 7; i++) begin
      send_op(2'b11, 4'b0000, 8'h00);
      if (stk_pop === 1'b1) pops++;
      step();
      step();
    end
    checks++;
    if (pops != 7 || depth !== 3'd0 || unf_err !== 1'b0) begin
      failures++;
      $display("FAIL unnest7: pops=%0d depth=%0d unf=%b required 7 0 0", pops, depth, unf_err);
    end
    send_op(2'b11, 4'b0000, 8'h00);
    checks++;
    if (stk_pop !== 1'b0 || unf_err !== 1'b1 || depth !== 3'd0 || ovf_err !== 1'b1) begin
      failures++;
      $display("FAIL underflow_endif: pop=%b unf=%b depth=%0d ovf=%b required 0 1 0 1", stk_pop, unf_err, depth, ovf_err);
    end
    step();
    step();
    send_op(2'b10, 4'b0000, 8'h70);
    checks++;
    if (stk_comp !== 1'b0 || unf_err !== 1'b1) begin
      failures++;
      $display("FAIL underflow_else: comp=%b unf=%b required 0 1", stk_comp, unf_err);
    end
    stk_all_false = 1'b1;
    step();
    checks++;
    if (redirect_valid !== 1'b0) begin
      failures++;
      $display("FAIL underflow_noredirect: rv=%b required 0", redirect_valid);
    end
    step();
    stk_all_false = 1'b0;
    $display("txn ENDIF/ELSE at depth 0: unf=%b", unf_err);
  endtask

  task automatic test_back_to_back();
    int pushes;
    pushes = 0;
    stk_tos = 4'b1111; stk_all_false = 1'b0;
    op_code = 2'b01; op_pred = 4'b0110; op_target = 8'h80;
    op_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (op_ready !== (k % 3 == 0)) begin
        failures++;
        $display("FAIL b2b_ready[%0d]: ready=%b required %b", k, op_ready, (k % 3 == 0));
      end
      if (stk_push === 1'b1) pushes++;
      step();
    end
    op_valid = 1'b0;
    checks++;
    if (pushes != 3 || depth !== 3'd3 || stk_d_in !== 4'b0110) begin
      failures++;
      $display("FAIL b2b_pushes: pushes=%0d depth=%0d din=%b required 3 3 0110", pushes, depth, stk_d_in);
    end
    $display("txn back-to-back IF x3: pushes=%0d depth=%0d", pushes, depth);
  endtask

  task automatic test_reset_mid_issue();
    stk_tos = 4'b1111; stk_all_false = 1'b0;
    send_op(2'b01, 4'b1100, 8'h90);
    checks++;
    if (stk_push !== 1'b1 || depth !== 3'd4) begin
      failures++;
      $display("FAIL rst_pre: push=%b depth=%0d required 1 4", stk_push, depth);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (stk_push !== 1'b0 || depth !== 3'd0 || op_ready !== 1'b1 || ovf_err !== 1'b0 ||
        unf_err !== 1'b0 || redirect_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_issue: push=%b depth=%0d ready=%b ovf=%b unf=%b rv=%b required 0 0 1 0 0 0",
               stk_push, depth, op_ready, ovf_err, unf_err, redirect_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    $display("txn reset during ISSUE: push=%b depth=%0d ready=%b", stk_push, depth, op_ready);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_nop();
    test_if_push();
    test_if_redirect();
    test_if_else_endif();
    test_overflow_underflow();
    test_back_to_back();
    test_reset_mid_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded required completion");
    $fatal(1, "timeout");
  end

endmodule
